// File: rtl/svc_axi_arbiter_rd.sv
// ============================================================================
// Module   : svc_axi_arbiter_rd
// Purpose  : Round-robin, per-burst arbiter sharing one downstream AXI read
//            port among NUM_M upstream read masters (IDs pass through).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module svc_axi_arbiter_rd #(
   parameter int NUM_M          = 2,
   parameter int AXI_ADDR_WIDTH = 20,
   parameter int AXI_DATA_WIDTH = 16,
   parameter int AXI_ID_WIDTH   = 4
) (
   input  logic                             clk,
   input  logic                             rst,

   input  logic [NUM_M-1:0]                 s_axi_arvalid,
   input  logic [NUM_M*AXI_ID_WIDTH-1:0]    s_axi_arid,
   input  logic [NUM_M*AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
   input  logic [NUM_M*8-1:0]               s_axi_arlen,
   input  logic [NUM_M*3-1:0]               s_axi_arsize,
   input  logic [NUM_M*2-1:0]               s_axi_arburst,
   output logic [NUM_M-1:0]                 s_axi_arready,

   output logic [NUM_M-1:0]                 s_axi_rvalid,
   output logic [AXI_ID_WIDTH-1:0]          s_axi_rid,
   output logic [AXI_DATA_WIDTH-1:0]        s_axi_rdata,
   output logic [1:0]                       s_axi_rresp,
   output logic                             s_axi_rlast,
   input  logic [NUM_M-1:0]                 s_axi_rready,

   output logic                             m_axi_arvalid,
   output logic [AXI_ID_WIDTH-1:0]          m_axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0]        m_axi_araddr,
   output logic [7:0]                       m_axi_arlen,
   output logic [2:0]                       m_axi_arsize,
   output logic [1:0]                       m_axi_arburst,
   input  logic                             m_axi_arready,

   input  logic                             m_axi_rvalid,
   input  logic [AXI_ID_WIDTH-1:0]          m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]        m_axi_rdata,
   input  logic [1:0]                       m_axi_rresp,
   input  logic                             m_axi_rlast,
   output logic                             m_axi_rready
);

   localparam int c_GW = $clog2(NUM_M);
   localparam int c_AW = AXI_ADDR_WIDTH;
   localparam int c_IW = AXI_ID_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t            r_state;
   logic [c_GW-1:0]   r_grant;
   logic [c_GW-1:0]   r_last_grant;

   logic [c_GW-1:0]   w_pick;
   logic [c_GW-1:0]   w_cand;
   logic              w_found;

   logic [c_IW-1:0]   w_arid    [NUM_M];
   logic [c_AW-1:0]   w_araddr  [NUM_M];
   logic [7:0]        w_arlen   [NUM_M];
   logic [2:0]        w_arsize  [NUM_M];
   logic [1:0]        w_arburst [NUM_M];

   for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
      assign w_arid[gi]    = s_axi_arid[gi*c_IW +: c_IW];
      assign w_araddr[gi]  = s_axi_araddr[gi*c_AW +: c_AW];
      assign w_arlen[gi]   = s_axi_arlen[gi*8 +: 8];
      assign w_arsize[gi]  = s_axi_arsize[gi*3 +: 3];
      assign w_arburst[gi] = s_axi_arburst[gi*2 +: 2];
   end

   // Scan from the master after the last one served, wrapping, so the most
   // recently served master is considered last.
   always_comb begin
      w_pick  = r_last_grant;
      w_cand  = '0;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_M; k++) begin
         w_cand = c_GW'((int'(r_last_grant) + k) % NUM_M);
         if (!w_found && s_axi_arvalid[w_cand]) begin
            w_pick  = w_cand;
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= c_GW'(NUM_M - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant <= w_pick;
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (m_axi_arvalid && m_axi_arready) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                  r_last_grant <= r_grant;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Handshake steering: only the granted master sees ready/valid, and only
   // in the phase that owns that channel.
   always_comb begin
      m_axi_arvalid = 1'b0;
      s_axi_arready = '0;
      s_axi_rvalid  = '0;
      m_axi_rready  = 1'b0;
      if (r_state == ST_ADDR) begin
         m_axi_arvalid          = s_axi_arvalid[r_grant];
         s_axi_arready[r_grant] = m_axi_arready;
      end
      if (r_state == ST_DATA) begin
         s_axi_rvalid[r_grant] = m_axi_rvalid;
         m_axi_rready          = s_axi_rready[r_grant];
      end
   end

   assign m_axi_arid    = w_arid[r_grant];
   assign m_axi_araddr  = w_araddr[r_grant];
   assign m_axi_arlen   = w_arlen[r_grant];
   assign m_axi_arsize  = w_arsize[r_grant];
   assign m_axi_arburst = w_arburst[r_grant];

   assign s_axi_rid     = m_axi_rid;
   assign s_axi_rdata   = m_axi_rdata;
   assign s_axi_rresp   = m_axi_rresp;
   assign s_axi_rlast   = m_axi_rlast;

endmodule

`default_nettype wire

// File: tb/tb_svc_axi_arbiter_rd.sv
// ============================================================================
// Module   : tb_svc_axi_arbiter_rd
// Purpose  : Directed plus randomized bench for svc_axi_arbiter_rd against a
//            round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_svc_axi_arbiter_rd;

   localparam int NUM_M = 2;
   localparam int AW    = 20;
   localparam int DW    = 16;
   localparam int IDW   = 4;
   localparam int GW    = $clog2(NUM_M);
   typedef logic [GW-1:0] idx_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst;
   logic [NUM_M-1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
   logic [NUM_M*IDW-1:0]  s_arid;
   logic [NUM_M*AW-1:0]   s_araddr;
   logic [NUM_M*8-1:0]    s_arlen;
   logic [NUM_M*3-1:0]    s_arsize;
   logic [NUM_M*2-1:0]    s_arburst;
   logic [IDW-1:0]        s_rid;
   logic [DW-1:0]         s_rdata;
   logic [1:0]            s_rresp;
   logic                  s_rlast;
   logic                  m_arvalid, m_arready;
   logic [IDW-1:0]        m_arid;
   logic [AW-1:0]         m_araddr;
   logic [7:0]            m_arlen;
   logic [2:0]            m_arsize;
   logic [1:0]            m_arburst;
   logic                  m_rvalid, m_rlast, m_rready;
   logic [IDW-1:0]        m_rid;
   logic [DW-1:0]         m_rdata;
   logic [1:0]            m_rresp;

   logic [AW-1:0]  q_addr  [NUM_M];
   logic [IDW-1:0] q_id    [NUM_M];
   logic [7:0]     q_len   [NUM_M];
   logic [2:0]     q_size  [NUM_M];
   logic [1:0]     q_burst [NUM_M];

   always_comb begin
      for (int i = 0; i < NUM_M; i++) begin
         s_araddr[i*AW +: AW]   = q_addr[i];
         s_arid[i*IDW +: IDW]   = q_id[i];
         s_arlen[i*8 +: 8]      = q_len[i];
         s_arsize[i*3 +: 3]     = q_size[i];
         s_arburst[i*2 +: 2]    = q_burst[i];
      end
   end

   svc_axi_arbiter_rd #(
      .NUM_M(NUM_M), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axi_arvalid(s_arvalid), .s_axi_arid(s_arid), .s_axi_araddr(s_araddr),
      .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst),
      .s_axi_arready(s_arready),
      .s_axi_rvalid(s_rvalid), .s_axi_rid(s_rid), .s_axi_rdata(s_rdata),
      .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast), .s_axi_rready(s_rready),
      .m_axi_arvalid(m_arvalid), .m_axi_arid(m_arid), .m_axi_araddr(m_araddr),
      .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
      .m_axi_arready(m_arready),
      .m_axi_rvalid(m_rvalid), .m_axi_rid(m_rid), .m_axi_rdata(m_rdata),
      .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast), .m_axi_rready(m_rready)
   );

   int total = 0;
   int bad   = 0;
   int last_m;

   function automatic logic [NUM_M-1:0] onehot(input int m);
      return NUM_M'(1) << m;
   endfunction

   // Reference arbitration: first requester after the last master served.
   function automatic int rr_pick(input int last, input logic [NUM_M-1:0] mask);
      for (int k = 1; k <= NUM_M; k++) begin
         if ((mask & onehot((last + k) % NUM_M)) != '0) return (last + k) % NUM_M;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_fields(input int m, input logic [AW-1:0] a,
                             input logic [IDW-1:0] id, input logic [7:0] len);
      q_addr[idx_t'(m)]  = a;
      q_id[idx_t'(m)]    = id;
      q_len[idx_t'(m)]   = len;
      q_size[idx_t'(m)]  = 3'd1;
      q_burst[idx_t'(m)] = 2'd1;
   endtask

   task automatic set_req(input int m, input logic [AW-1:0] a,
                          input logic [IDW-1:0] id, input logic [7:0] len);
      set_fields(m, a, id, len);
      s_arvalid = s_arvalid | onehot(m);
   endtask

   // Entered at a falling edge with the DUT idle and requests driven; returns
   // at the falling edge after the rlast handshake (DUT idle again).
   task automatic serve(input int bp_beat, input int bp_cycles, input bit keep,
                        input int abort_beat, input logic [NUM_M-1:0] mid_mask,
                        input int dbase, input int ar_delay);
      int g, waited, len;
      logic [NUM_M-1:0] oh;
      logic [DW-1:0] d;
      logic [1:0] resp;
      g = rr_pick(last_m, s_arvalid);
      if (g < 0) return;
      oh = onehot(g);
      #1;
      chk("ar_bubble", 32'(m_arvalid), 0);
      waited = 0;
      do begin
         @(negedge clk); #1;
         waited++;
      end while (!m_arvalid && waited < 4);
      chk("ar_latency", waited, 1);
      if (!m_arvalid) return;
      chk("ar_addr",  32'(m_araddr),  32'(q_addr[idx_t'(g)]));
      chk("ar_id",    32'(m_arid),    32'(q_id[idx_t'(g)]));
      chk("ar_len",   32'(m_arlen),   32'(q_len[idx_t'(g)]));
      chk("ar_size",  32'(m_arsize),  32'(q_size[idx_t'(g)]));
      chk("ar_burst", 32'(m_arburst), 32'(q_burst[idx_t'(g)]));
      chk("arready_idle", 32'(s_arready), 0);
      repeat (ar_delay) begin
         @(negedge clk); #1;
         chk("ar_hold_valid", 32'(m_arvalid), 1);
         chk("ar_hold_ready", 32'(s_arready), 0);
      end
      m_arready = 1'b1;
      #1;
      chk("arready_route", 32'(s_arready), 32'(oh));
      len = int'(q_len[idx_t'(g)]);
      @(negedge clk);
      m_arready = 1'b0;
      if (!keep) s_arvalid = s_arvalid & ~oh;
      for (int b = 0; b <= len; b++) begin
         if (b == 1) s_arvalid = s_arvalid | mid_mask;
         if ($urandom_range(0, 3) == 0) begin
            m_rvalid = 1'b0;
            s_rready = NUM_M'($urandom);
            #1;
            chk("gap_rvalid", 32'(s_rvalid), 0);
            chk("gap_rready", 32'(m_rready), 32'((s_rready & oh) != '0));
            @(negedge clk);
         end
         d    = (dbase >= 0) ? DW'(dbase + b) : DW'($urandom);
         resp = 2'($urandom);
         m_rvalid = 1'b1;
         m_rdata  = d;
         m_rid    = q_id[idx_t'(g)];
         m_rresp  = resp;
         m_rlast  = (b == len);
         if (b == abort_beat) begin
            s_rready = oh;
            rst = 1'b1;
            #1;
            chk("abort_rvalid_pre", 32'(s_rvalid), 32'(oh));
            @(negedge clk);
            rst = 1'b0;
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            #1;
            chk("abort_rvalid",  32'(s_rvalid),  0);
            chk("abort_rready",  32'(m_rready),  0);
            chk("abort_arvalid", 32'(m_arvalid), 0);
            chk("abort_arready", 32'(s_arready), 0);
            chk("abort_mux0",    32'(m_araddr),  32'(q_addr[0]));
            last_m = NUM_M - 1;
            return;
         end
         if (b == bp_beat) begin
            repeat (bp_cycles) begin
               s_rready = NUM_M'($urandom) & ~oh;
               #1;
               chk("bp_rready", 32'(m_rready), 0);
               chk("bp_rvalid", 32'(s_rvalid), 32'(oh));
               @(negedge clk);
            end
         end
         s_rready = NUM_M'($urandom) | oh;
         #1;
         chk("r_valid",   32'(s_rvalid),  32'(oh));
         chk("r_data",    32'(s_rdata),   32'(d));
         chk("r_id",      32'(s_rid),     32'(q_id[idx_t'(g)]));
         chk("r_resp",    32'(s_rresp),   32'(resp));
         chk("r_last",    32'(s_rlast),   32'(b == len));
         chk("r_ready",   32'(m_rready),  1);
         chk("r_arvalid", 32'(m_arvalid), 0);
         chk("r_arready", 32'(s_arready), 0);
         @(negedge clk);
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = '0;
      last_m   = g;
      #1;
      chk("post_rvalid",  32'(s_rvalid),  0);
      chk("post_rready",  32'(m_rready),  0);
      chk("post_arvalid", 32'(m_arvalid), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      s_arvalid = '0;
      s_rready  = '0;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rid     = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rlast   = 1'b0;
      set_fields(0, 20'h12345, 4'h3, 8'd0);
      set_fields(1, 20'h54321, 4'hC, 8'd0);
      last_m = NUM_M - 1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset: nothing asserted, payload muxed from master 0.
      repeat (5) begin
         @(negedge clk); #1;
         chk("rst_arready", 32'(s_arready), 0);
         chk("rst_rvalid",  32'(s_rvalid),  0);
         chk("rst_arvalid", 32'(m_arvalid), 0);
         chk("rst_rready",  32'(m_rready),  0);
      end
      chk("rst_mux0", 32'(m_araddr), 32'(q_addr[0]));

      // Single master, 4-beat burst.
      @(negedge clk);
      set_req(0, 20'hA000, 4'hD, 8'd3);
      serve(-1, 0, 1'b0, -1, '0, 16'hD000, 0);

      // Both masters continuous single-beat requests: strict alternation.
      set_req(0, 20'hB000, 4'h1, 8'd0);
      set_req(1, 20'hC000, 4'h2, 8'd0);
      repeat (4) serve(-1, 0, 1'b1, -1, '0, -1, 0);
      s_arvalid = '0;
      @(negedge clk);

      // Master 0 arrives mid-burst of master 1 and waits for the turnaround.
      set_fields(0, 20'hF000, 4'h8, 8'd1);
      set_req(1, 20'hE000, 4'h5, 8'd3);
      serve(-1, 0, 1'b0, -1, NUM_M'(1), -1, 1);
      serve(-1, 0, 1'b0, -1, '0, -1, 0);

      // R backpressure for three cycles on beat 1.
      set_req(0, 20'h9000, 4'h3, 8'd3);
      serve(1, 3, 1'b0, -1, '0, -1, 0);

      // Master 0 just served, master 1 mid-burst gets reset; master 0 must
      // then win over master 1 again.
      set_req(1, 20'h7000, 4'h6, 8'd3);
      serve(-1, 0, 1'b0, 2, '0, -1, 0);
      set_req(0, 20'h6000, 4'h4, 8'd0);
      set_req(1, 20'h5000, 4'h7, 8'd0);
      serve(-1, 0, 1'b0, -1, '0, -1, 0);

      // Randomized request mixes, lengths, stalls and backpressure.
      for (int it = 0; it < 24; it++) begin
         for (int m = 0; m < NUM_M; m++) begin
            if ((s_arvalid & onehot(m)) == '0 && $urandom_range(0, 1) == 1)
               set_req(m, AW'($urandom), IDW'($urandom), 8'($urandom_range(0, 3)));
         end
         if (s_arvalid == '0)
            set_req(int'($urandom_range(0, NUM_M - 1)), AW'($urandom),
                    IDW'($urandom), 8'($urandom_range(0, 3)));
         serve(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
               1'($urandom_range(0, 1)), -1, '0, -1, int'($urandom_range(0, 2)));
      end
      s_arvalid = '0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
